des_sbox_sequencer: RTL and testbench
=====================================

// Module: des_sbox_sequencer
// PURPOSE
//  Time-multiplexed DES S-box stage: accepts one 48-bit post-XOR (E(R)^K) word, feeds its eight
//  6-bit chunks through LANES shared S-box lookups over 8/LANES cycles, and returns the 32-bit
//  S-layer result (pre-P-permutation). Sits between the round key-mix XOR and the P permutation
//  in the round datapath; trades area (one lookup instead of eight) for throughput.
// PARAMETERS
//  LANES  1  lookups per cycle; legal values 1,2,4,8 (elaboration error otherwise)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  n_rst      in   1   asynchronous active-low reset
//  clear      in   1   synchronous abort: drop current job, return to IDLE
//  in_valid   in   1   in_data valid
//  in_ready   out  1   block can accept a job (high only in IDLE)
//  in_data    in   48  chunk i (S-box i+1) = in_data[47-6i -: 6], i=0..7
//  out_valid  out  1   out_data holds a completed result
//  out_ready  in   1   consumer takes result
//  out_data   out  32  S(i+1) result in out_data[31-4i -: 4]
// BEHAVIOUR
//  - Reset (n_rst=0, async): state=IDLE, cnt=0, in_ready=1, out_valid=0, out_data=0, data regs=0.
//  - FSM states IDLE, RUN, DONE (enum in des_pkg).
//    IDLE: in_ready=1. in_valid=1 on an edge -> latch in_data, cnt=0, go RUN.
//    RUN : each edge looks up chunks cnt*LANES .. cnt*LANES+LANES-1 (chunk j uses S-box j+1,
//          row={c[5],c[0]}, col=c[4:1]) and writes nibbles into result reg; cnt++.
//          On the edge processing the last group (cnt==8/LANES-1): cnt->0, go DONE.
//    DONE: out_valid=1, out_data stable. out_ready=1 on an edge -> go IDLE, out_valid=0.
//  - Latency: out_valid rises exactly 8/LANES edges after the accepting edge (8 for LANES=1).
//    Throughput: one job per 8/LANES+2 cycles when out_ready held high.
//  - No accept in DONE or RUN (in_ready=0); in_data ignored outside IDLE accept edge.
//  - out_data registered; only changes during RUN/accept; held in DONE until handshake.
//    Unwritten nibbles during RUN keep prior values (not externally visible: out_valid=0).
//  - clear=1: next edge -> IDLE, cnt=0, out_valid=0; clear has priority over in_valid
//    and out_ready on the same edge (no accept, no completion). out_data retains last value.
//  - n_rst asserted mid-RUN/DONE: job lost, outputs to reset values immediately.
//  - cnt width = clog2(8/LANES), min 1 bit; cnt never exceeds 8/LANES-1 (wraps to 0 at DONE).
//  - No combinational path in_valid->in_ready or out_ready->out_valid (both state decodes).
// STRUCTURE
//  - des_pkg: typedef enum logic [1:0] {IDLE,RUN,DONE} sbox_seq_state_t; constant
//    SBOX_TABLE [8][4][16] of 4-bit values (standard DES S1..S8); localparam NCHUNK=8.
//  - Sub-module des_sbox_lut (comb): inputs box_sel[2:0], din[5:0]; output dout[3:0];
//    instantiated LANES times via generate, box_sel = cnt*LANES+lane.
//  - Top: FSM, cnt, 48-bit input reg, 32-bit result reg, handshake decode.
// TESTING
//  1. in_data=48'h0, LANES=1 -> out_valid 8 edges after accept, out_data=32'hEFA72C4D.
//  2. in_data=48'hFFFF_FFFF_FFFF -> out_data=32'hD9CE3DCB; repeat with LANES=2,4,8,
//     same value, latency 4/2/1.
//  3. out_ready held low 20 cycles in DONE -> out_valid and out_data stable, in_ready=0;
//     in_valid pulses ignored; release -> one completion, back to IDLE next cycle.
//  4. clear asserted at RUN cnt=3 with in_valid=1 -> IDLE next edge, no out_valid,
//     no accept; following job in_data=0 returns 32'hEFA72C4D.
//  5. n_rst low mid-RUN and in DONE -> outputs reset asynchronously (before next edge);
//     first job after release correct.
//  6. Random 1000 jobs, random in_valid/out_ready stalls vs. golden DES S-layer model;
//     check no loss/duplication and cnt never exceeds 8/LANES-1.

Source files
------------

// File: rtl/des_pkg.sv
// Shared types and constants for the time-multiplexed DES S-box stage.
// SBOX_TABLE[box][row][col] holds the standard DES S1..S8 4-bit outputs.
package des_pkg;

    localparam int unsigned NCHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sbox_seq_state_t;

    localparam logic [3:0] SBOX_TABLE [8][4][16] = '{
        '{ // S1
            '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7},
            '{4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8},
            '{4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0},
            '{4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13}
        },
        '{ // S2
            '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10},
            '{4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5},
            '{4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15},
            '{4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9}
        },
        '{ // S3
            '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8},
            '{4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1},
            '{4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7},
            '{4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12}
        },
        '{ // S4
            '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15},
            '{4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9},
            '{4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4},
            '{4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14}
        },
        '{ // S5
            '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9},
            '{4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6},
            '{4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14},
            '{4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3}
        },
        '{ // S6
            '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11},
            '{4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8},
            '{4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6},
            '{4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13}
        },
        '{ // S7
            '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1},
            '{4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6},
            '{4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2},
            '{4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12}
        },
        '{ // S8
            '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7},
            '{4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2},
            '{4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8},
            '{4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
        }
    };

endpackage

// File: rtl/des_sbox_lut.sv
// Single combinational DES S-box lookup; box_sel picks S1..S8 (0..7).
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [2:0] box_sel,
    input  logic [5:0] din,
    output logic [3:0] dout
);

    // Outer bits select the row, inner four bits the column.
    always_comb begin
        dout = SBOX_TABLE[box_sel][{din[5], din[0]}][din[4:1]];
    end

endmodule

// File: rtl/des_sbox_sequencer.sv
// DES S-layer stage sharing LANES S-box lookups across 8/LANES cycles per job.
// Valid/ready job interface on both sides; result held in DONE until taken.
module des_sbox_sequencer
    import des_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int unsigned NGROUP = NCHUNK / LANES;
    localparam int unsigned CNT_W  = (NGROUP > 1) ? $clog2(NGROUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGROUP - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_sequencer: LANES must be 1, 2, 4 or 8");
    end

    sbox_seq_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [47:0]      in_reg_q, in_reg_d;
    logic [31:0]      res_q, res_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [2:0] lane_sel  [LANES];
    logic [5:0] lane_din  [LANES];
    logic [3:0] lane_dout [LANES];

    // Lane g handles chunk cnt*LANES+g of the latched word.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_sel[g] = 3'(32'(cnt_q) * LANES + 32'(g));
        assign lane_din[g] = 6'(in_reg_q >> (6'd42 - ({3'b000, lane_sel[g]} * 6'd6)));

        des_sbox_lut u_lut (
            .box_sel (lane_sel[g]),
            .din     (lane_din[g]),
            .dout    (lane_dout[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_reg_d = in_reg_q;
        res_d    = res_q;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_reg_d = in_data;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    // Chunk j lands in nibble out_data[31-4j -: 4].
                    for (int l = 0; l < int'(LANES); l++) begin
                        res_d = (res_d & ~(32'hF << (5'd28 - {lane_sel[l], 2'b00})))
                              | (32'(lane_dout[l]) << (5'd28 - {lane_sel[l], 2'b00}));
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_reg_q    <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_reg_q    <= in_reg_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Bench for des_sbox_sequencer: four instances (LANES 1,2,4,8), directed steps
// followed by randomized jobs scored against a table-driven DES S-layer model.
module tb_des_sbox_sequencer;

    // Standard DES S-boxes, one 64-bit word per row, column 0 in the top nibble.
    localparam logic [63:0] SROW [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic        clk;
    logic        n_rst;
    logic        clear_a     [4];
    logic        in_valid_a  [4];
    logic        in_ready_a  [4];
    logic [47:0] in_data_a   [4];
    logic        out_valid_a [4];
    logic        out_ready_a [4];
    logic [31:0] out_data_a  [4];

    int n_total = 0;
    int n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_sequencer #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .clear     (clear_a[g]),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g])
        );
    end

    function automatic logic [31:0] golden(input logic [47:0] x);
        logic [31:0] r;
        logic [5:0]  c;
        logic [63:0] w;
        int          col;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            c   = 6'(x >> (42 - 6 * i));
            w   = SROW[i * 4 + 2 * int'(c[5]) + int'(c[0])];
            col = int'(c[4:1]);
            r   = (r << 4) | 32'(4'(w >> (60 - 4 * col)));
        end
        return r;
    endfunction

    function automatic logic [47:0] rnd48();
        return 48'({$urandom, $urandom});
    endfunction

    function automatic int unsigned cnt_of(input int k);
        case (k)
            0:       return 32'(g_dut[0].u_dut.cnt_q);
            1:       return 32'(g_dut[1].u_dut.cnt_q);
            2:       return 32'(g_dut[2].u_dut.cnt_q);
            default: return 32'(g_dut[3].u_dut.cnt_q);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!out_valid_a[k] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // One complete job: accept, check latency and result, complete handshake.
    task automatic run_job(input int k, input logic [47:0] d, input logic [31:0] exp, input string tag);
        int lat;
        check({tag, "_idle_ready"}, 64'(in_ready_a[k]), 64'd1);
        in_valid_a[k]  = 1'b1;
        in_data_a[k]   = d;
        out_ready_a[k] = 1'b0;
        tick();
        in_valid_a[k] = 1'b0;
        in_data_a[k]  = rnd48();
        wait_valid(k, lat);
        check({tag, "_latency"}, 64'(lat), 64'(8 >> k));
        check({tag, "_data"}, 64'(out_data_a[k]), 64'(exp));
        check({tag, "_busy"}, 64'(in_ready_a[k]), 64'd0);
        out_ready_a[k] = 1'b1;
        tick();
        out_ready_a[k] = 1'b0;
        check({tag, "_done_valid"}, 64'(out_valid_a[k]), 64'd0);
        check({tag, "_done_ready"}, 64'(in_ready_a[k]), 64'd1);
    endtask

    task automatic random_run(input int k, input int n);
        logic [31:0] q[$];
        logic [31:0] exp;
        int          sent, got, cyc;
        int unsigned maxc;
        bit          excl_ok;
        sent = 0; got = 0; cyc = 0; maxc = 0; excl_ok = 1'b1;
        while (got < n && cyc < n * 40) begin
            if (cnt_of(k) > maxc) maxc = cnt_of(k);
            if (in_ready_a[k] && out_valid_a[k]) excl_ok = 1'b0;
            in_valid_a[k]  = (sent < n) && ($urandom_range(0, 3) != 0);
            in_data_a[k]   = rnd48();
            out_ready_a[k] = ($urandom_range(0, 2) != 0);
            if (in_valid_a[k] && in_ready_a[k]) begin
                q.push_back(golden(in_data_a[k]));
                sent++;
            end
            if (out_valid_a[k] && out_ready_a[k]) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_out", 64'(out_valid_a[k]), 64'd0);
                end else begin
                    exp = q.pop_front();
                    check($sformatf("rnd_data_l%0d", 1 << k), 64'(out_data_a[k]), 64'(exp));
                end
                got++;
            end
            tick();
            cyc++;
        end
        in_valid_a[k]  = 1'b0;
        out_ready_a[k] = 1'b0;
        check($sformatf("rnd_got_l%0d", 1 << k), 64'(got), 64'(n));
        check($sformatf("rnd_sent_l%0d", 1 << k), 64'(sent), 64'(n));
        check($sformatf("rnd_leftover_l%0d", 1 << k), 64'(q.size()), 64'd0);
        check($sformatf("rnd_cnt_max_l%0d", 1 << k), 64'(maxc), 64'((8 >> k) - 1));
        check($sformatf("rnd_ready_valid_excl_l%0d", 1 << k), 64'(excl_ok), 64'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic [47:0] d;
        int          lat;
        bit          ok;

        for (int k = 0; k < 4; k++) begin
            clear_a[k] = 1'b0; in_valid_a[k] = 1'b0; in_data_a[k] = '0; out_ready_a[k] = 1'b0;
        end
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_in_ready_l%0d", 1 << k), 64'(in_ready_a[k]), 64'd1);
            check($sformatf("rst_out_valid_l%0d", 1 << k), 64'(out_valid_a[k]), 64'd0);
            check($sformatf("rst_out_data_l%0d", 1 << k), 64'(out_data_a[k]), 64'd0);
        end
        #1 n_rst = 1'b1;
        tick();

        // Known vectors across every lane count.
        for (int k = 0; k < 4; k++) begin
            run_job(k, 48'h0, 32'hEFA72C4D, $sformatf("zero_l%0d", 1 << k));
            run_job(k, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, $sformatf("ones_l%0d", 1 << k));
        end

        // Consumer stall in DONE with in_valid pulses that must be ignored.
        d = rnd48();
        in_valid_a[0] = 1'b1; in_data_a[0] = d;
        tick();
        in_valid_a[0] = 1'b0;
        wait_valid(0, lat);
        check("hold_latency", 64'(lat), 64'd8);
        held = out_data_a[0];
        check("hold_data", 64'(held), 64'(golden(d)));
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid_a[0] = i[0];
            in_data_a[0]  = rnd48();
            tick();
            if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== held || in_ready_a[0] !== 1'b0) ok = 1'b0;
        end
        in_valid_a[0] = 1'b0;
        check("hold_stable", 64'(ok), 64'd1);
        out_ready_a[0] = 1'b1;
        tick();
        out_ready_a[0] = 1'b0;
        check("hold_release_valid", 64'(out_valid_a[0]), 64'd0);
        check("hold_release_ready", 64'(in_ready_a[0]), 64'd1);
        tick();
        check("hold_no_ghost_job", 64'(in_ready_a[0]), 64'd1);

        // Abort mid-RUN at cnt=3 while in_valid is high.
        in_valid_a[0] = 1'b1; in_data_a[0] = rnd48();
        tick();
        in_valid_a[0] = 1'b0;
        repeat (3) tick();
        check("clr_cnt_before", 64'(cnt_of(0)), 64'd3);
        clear_a[0] = 1'b1; in_valid_a[0] = 1'b1; in_data_a[0] = 48'h1234_5678_9ABC;
        tick();
        clear_a[0] = 1'b0; in_valid_a[0] = 1'b0;
        check("clr_ready", 64'(in_ready_a[0]), 64'd1);
        check("clr_cnt_after", 64'(cnt_of(0)), 64'd0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) ok = 1'b0;
        end
        check("clr_no_accept", 64'(ok), 64'd1);
        run_job(0, 48'h0, 32'hEFA72C4D, "clr_next");

        // Abort in DONE beats a simultaneous out_ready; result register is kept.
        d = rnd48();
        in_valid_a[0] = 1'b1; in_data_a[0] = d;
        tick();
        in_valid_a[0] = 1'b0;
        wait_valid(0, lat);
        held = out_data_a[0];
        clear_a[0] = 1'b1; out_ready_a[0] = 1'b1;
        tick();
        clear_a[0] = 1'b0; out_ready_a[0] = 1'b0;
        check("clrdone_valid", 64'(out_valid_a[0]), 64'd0);
        check("clrdone_ready", 64'(in_ready_a[0]), 64'd1);
        check("clrdone_data_kept", 64'(out_data_a[0]), 64'(golden(d)));

        // Asynchronous reset mid-RUN.
        in_valid_a[0] = 1'b1; in_data_a[0] = rnd48();
        tick();
        in_valid_a[0] = 1'b0;
        repeat (3) tick();
        n_rst = 1'b0;
        #1;
        check("arst_run_ready", 64'(in_ready_a[0]), 64'd1);
        check("arst_run_valid", 64'(out_valid_a[0]), 64'd0);
        check("arst_run_data", 64'(out_data_a[0]), 64'd0);
        #1 n_rst = 1'b1;
        tick();
        d = rnd48();
        run_job(0, d, golden(d), "arst_run_next");

        // Asynchronous reset while holding a result in DONE.
        in_valid_a[0] = 1'b1; in_data_a[0] = rnd48();
        tick();
        in_valid_a[0] = 1'b0;
        wait_valid(0, lat);
        n_rst = 1'b0;
        #1;
        check("arst_done_ready", 64'(in_ready_a[0]), 64'd1);
        check("arst_done_valid", 64'(out_valid_a[0]), 64'd0);
        check("arst_done_data", 64'(out_data_a[0]), 64'd0);
        #1 n_rst = 1'b1;
        tick();
        d = rnd48();
        run_job(0, d, golden(d), "arst_done_next");

        // Randomized traffic with stalls on both sides.
        random_run(0, 1000);
        random_run(1, 200);
        random_run(2, 200);
        random_run(3, 200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
